// File: rtl/usb_tx_sched.sv
// USB TX response scheduler: picks DATA0/ACK/NAK/STALL, enforces the inter-packet gap,
// starts the TX encoder and tracks the send. Optional build macro: USB_TX_SCHED_WATCHDOG_EN.
//
// state    | meaning
// ---------+----------------------------------------------------
// IDLE     | waiting for an IN token or OUT data-phase result
// GAP      | inter-packet gap countdown
// START    | one-cycle tx_start pulse to the encoder
// WAIT_ACT | waiting for the encoder to report transfer active
// BUSY     | packet on the wire
// DONE     | clean completion; data_sent when the packet was DATA0
module usb_tx_sched #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int IPG_BITS      = 2,
    parameter int START_TIMEOUT = 16
`ifdef USB_TX_SCHED_WATCHDOG_EN
    ,
    parameter int MAX_TX_CYCLES = 1200
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_token,
    input  logic       out_done,
    input  logic       out_ok,
    input  logic       halt,
    input  logic       tx_data_ready,
    input  logic       tx_transfer_active,
    input  logic       tx_error,
    input  logic       clear_status,
    output logic       tx_start,
    output logic [1:0] tx_packet,
    output logic       sched_busy,
    output logic       data_sent,
    output logic       sched_error,
    output logic       req_overrun
);

    localparam logic [1:0] PKT_DATA0 = 2'd0;
    localparam logic [1:0] PKT_ACK   = 2'd1;
    localparam logic [1:0] PKT_NAK   = 2'd2;
    localparam logic [1:0] PKT_STALL = 2'd3;

    localparam int GAP_CLKS = IPG_BITS * CLKS_PER_BIT;
`ifdef USB_TX_SCHED_WATCHDOG_EN
    localparam int WD_CLKS = MAX_TX_CYCLES;
`else
    localparam int WD_CLKS = 0;
`endif
    localparam int MAX_A   = (GAP_CLKS > START_TIMEOUT) ? GAP_CLKS : START_TIMEOUT;
    localparam int CNT_MAX = (WD_CLKS > MAX_A) ? WD_CLKS : MAX_A;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Down-counters are loaded with terminal-1 on state entry and expire at zero.
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'((START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0);
`ifdef USB_TX_SCHED_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LOAD  = CNT_W'((WD_CLKS > 0) ? WD_CLKS - 1 : 0);
`endif

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        START,
        WAIT_ACT,
        BUSY,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       pkt_nxt;
    logic             ovr_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            tx_packet   <= PKT_DATA0;
            req_overrun <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            tx_packet <= pkt_nxt;
            if (ovr_set)
                req_overrun <= 1'b1;
            else if (clear_status)
                req_overrun <= 1'b0;
        end
    end

    // A second simultaneous request in IDLE, or any request once a response is in flight, is lost.
    assign ovr_set    = (state == IDLE) ? (in_token && out_done) : (in_token || out_done);
    assign sched_busy = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = (cnt != '0) ? cnt - 1'b1 : '0;
        pkt_nxt     = tx_packet;
        tx_start    = 1'b0;
        data_sent   = 1'b0;
        sched_error = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (in_token || out_done) begin
                    if (in_token)
                        pkt_nxt = halt ? PKT_STALL : (tx_data_ready ? PKT_DATA0 : PKT_NAK);
                    else
                        pkt_nxt = halt ? PKT_STALL : (out_ok ? PKT_ACK : PKT_NAK);
                    if (GAP_CLKS == 0) begin
                        state_nxt = START;
                    end else begin
                        state_nxt = GAP;
                        cnt_nxt   = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (cnt == '0)
                    state_nxt = START;
            end
            START: begin
                tx_start  = 1'b1;
                state_nxt = WAIT_ACT;
                cnt_nxt   = TO_LOAD;
            end
            WAIT_ACT: begin
                if (tx_transfer_active) begin
                    state_nxt = BUSY;
`ifdef USB_TX_SCHED_WATCHDOG_EN
                    cnt_nxt   = WD_LOAD;
`else
                    cnt_nxt   = '0;
`endif
                end else if (cnt == '0) begin
                    sched_error = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            BUSY: begin
                if (tx_error) begin
                    sched_error = 1'b1;
                    state_nxt   = IDLE;
                end else if (!tx_transfer_active) begin
                    state_nxt = DONE;
`ifdef USB_TX_SCHED_WATCHDOG_EN
                end else if (cnt == '0) begin
                    sched_error = 1'b1;
                    state_nxt   = IDLE;
`endif
                end
            end
            DONE: begin
                data_sent = (tx_packet == PKT_DATA0);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_usb_tx_sched.sv
// Bench for usb_tx_sched: table of request vectors with a simple TX encoder model,
// plus directed sequences for timeout, tx_error, reset-in-gap and the BUSY watchdog.
module tb_usb_tx_sched;

    logic       clk = 1'b0;
    logic       rst, in_token, out_done, out_ok, halt, tx_data_ready;
    logic       tx_transfer_active, tx_error, clear_status;
    logic       tx_start, sched_busy, data_sent, sched_error, req_overrun;
    logic [1:0] tx_packet;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    usb_tx_sched dut (
        .clk               (clk),
        .rst               (rst),
        .in_token          (in_token),
        .out_done          (out_done),
        .out_ok            (out_ok),
        .halt              (halt),
        .tx_data_ready     (tx_data_ready),
        .tx_transfer_active(tx_transfer_active),
        .tx_error          (tx_error),
        .clear_status      (clear_status),
        .tx_start          (tx_start),
        .tx_packet         (tx_packet),
        .sched_busy        (sched_busy),
        .data_sent         (data_sent),
        .sched_error       (sched_error),
        .req_overrun       (req_overrun)
    );

    typedef struct {
        logic       tok;
        logic       od;
        logic       ok;
        logic       hlt;
        logic       rdy;
        int         act_len;
        logic [1:0] exp_pkt;
        logic       exp_ds;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic request(input logic tok, input logic od, input logic ok,
                           input logic hlt, input logic rdy);
        step();
        in_token = tok; out_done = od; out_ok = ok; halt = hlt; tx_data_ready = rdy;
        #1;
    endtask

    // Clears the request lines and counts cycles until tx_start (expected 17 after the request).
    task automatic wait_start(input string name, output int lat, output int ovr1,
                              output int busy1, output int errs);
        lat = -1; ovr1 = -1; busy1 = -1; errs = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            in_token = 0; out_done = 0; out_ok = 0; halt = 0; tx_data_ready = 0;
            #1;
            if (c == 1) begin
                ovr1  = req_overrun;
                busy1 = sched_busy;
            end
            errs += int'(sched_error);
            if (tx_start) begin
                lat = c;
                break;
            end
        end
        chk({name, "_latency"}, lat, 17);
    endtask

    task automatic run_tx(input int act_len, output int ds_cnt, output int err_cnt,
                          output int st_cnt, output int ds_off, output int busy_end);
        ds_cnt = 0; err_cnt = 0; st_cnt = 0; ds_off = -1;
        for (int c = 1; c <= act_len; c++) begin
            step();
            tx_transfer_active = 1;
            #1;
            ds_cnt += int'(data_sent); err_cnt += int'(sched_error); st_cnt += int'(tx_start);
        end
        for (int c = 0; c < 6; c++) begin
            step();
            tx_transfer_active = 0;
            #1;
            if (data_sent && ds_off < 0) ds_off = c;
            ds_cnt += int'(data_sent); err_cnt += int'(sched_error); st_cnt += int'(tx_start);
        end
        busy_end = sched_busy;
    endtask

    initial begin
        #5000000;
        $display("FAIL global_timeout: got stuck, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, ovr1, busy1, errs, ds_cnt, err_cnt, st_cnt, ds_off, busy_end, errc, cnt;

        vecs[0] = '{tok:1, od:0, ok:0, hlt:0, rdy:1, act_len:300, exp_pkt:2'd0, exp_ds:1, exp_ovr:0};
        vecs[1] = '{tok:0, od:1, ok:0, hlt:0, rdy:0, act_len:20,  exp_pkt:2'd2, exp_ds:0, exp_ovr:0};
        vecs[2] = '{tok:0, od:1, ok:0, hlt:1, rdy:0, act_len:20,  exp_pkt:2'd3, exp_ds:0, exp_ovr:0};
        vecs[3] = '{tok:0, od:1, ok:1, hlt:0, rdy:1, act_len:15,  exp_pkt:2'd1, exp_ds:0, exp_ovr:0};
        vecs[4] = '{tok:1, od:0, ok:1, hlt:0, rdy:0, act_len:10,  exp_pkt:2'd2, exp_ds:0, exp_ovr:0};
        vecs[5] = '{tok:1, od:0, ok:1, hlt:1, rdy:1, act_len:10,  exp_pkt:2'd3, exp_ds:0, exp_ovr:0};
        vecs[6] = '{tok:1, od:1, ok:1, hlt:0, rdy:1, act_len:25,  exp_pkt:2'd0, exp_ds:1, exp_ovr:1};
        vecs[7] = '{tok:1, od:1, ok:1, hlt:0, rdy:0, act_len:12,  exp_pkt:2'd2, exp_ds:0, exp_ovr:1};

        rst = 1; in_token = 0; out_done = 0; out_ok = 0; halt = 0; tx_data_ready = 0;
        tx_transfer_active = 0; tx_error = 0; clear_status = 0;
        step(); step(); #1;
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_packet", tx_packet, 0);
        chk("rst_busy", sched_busy, 0);
        chk("rst_data_sent", data_sent, 0);
        chk("rst_sched_error", sched_error, 0);
        chk("rst_overrun", req_overrun, 0);
        step(); rst = 0; #1;

        for (int i = 0; i < 8; i++) begin
            request(vecs[i].tok, vecs[i].od, vecs[i].ok, vecs[i].hlt, vecs[i].rdy);
            chk($sformatf("v%0d_no_early_start", i), tx_start, 0);
            wait_start($sformatf("v%0d", i), lat, ovr1, busy1, errs);
            chk($sformatf("v%0d_tx_packet", i), tx_packet, vecs[i].exp_pkt);
            chk($sformatf("v%0d_overrun", i), ovr1, vecs[i].exp_ovr);
            chk($sformatf("v%0d_busy", i), busy1, 1);
            chk($sformatf("v%0d_gap_errors", i), errs, 0);
            run_tx(vecs[i].act_len, ds_cnt, err_cnt, st_cnt, ds_off, busy_end);
            chk($sformatf("v%0d_data_sent_count", i), ds_cnt, vecs[i].exp_ds);
            chk($sformatf("v%0d_sched_error_count", i), err_cnt, 0);
            chk($sformatf("v%0d_extra_starts", i), st_cnt, 0);
            if (vecs[i].exp_ds) chk($sformatf("v%0d_data_sent_cycle", i), ds_off, 1);
            chk($sformatf("v%0d_busy_end", i), busy_end, 0);
            step(); clear_status = 1; #1;
            step(); clear_status = 0; #1;
            chk($sformatf("v%0d_overrun_cleared", i), req_overrun, 0);
        end

        // Start timeout: encoder never goes active.
        request(0, 1, 1, 0, 0);
        wait_start("to", lat, ovr1, busy1, errs);
        errc = -1; cnt = 0; busy1 = -1; ds_cnt = 0;
        for (int c = 1; c <= 30; c++) begin
            step(); #1;
            if (sched_error && errc < 0) begin
                errc = c;
                chk("to_packet_held", tx_packet, 1);
            end
            cnt += int'(sched_error);
            ds_cnt += int'(data_sent);
            if (c == 17) busy1 = sched_busy;
        end
        chk("to_error_cycle", errc, 16);
        chk("to_error_pulses", cnt, 1);
        chk("to_busy_after", busy1, 0);
        chk("to_no_data_sent", ds_cnt, 0);

        // tx_error ignored before BUSY, aborts a DATA0 send inside BUSY.
        tx_error = 1;
        request(1, 0, 0, 0, 1);
        wait_start("te", lat, ovr1, busy1, errs);
        chk("te_ignored_in_gap", errs, 0);
        step(); tx_transfer_active = 1; #1;
        chk("te_ignored_in_wait", sched_error, 0);
        for (int c = 0; c < 50; c++) begin
            step(); tx_error = 0; #1;
        end
        step(); tx_error = 1; #1;
        chk("te_sched_error", sched_error, 1);
        chk("te_no_data_sent", data_sent, 0);
        step(); tx_error = 0; tx_transfer_active = 0; #1;
        chk("te_busy_after", sched_busy, 0);
        ds_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            step(); #1;
            ds_cnt += int'(data_sent);
        end
        chk("te_data_sent_never", ds_cnt, 0);

        // Dropped request in GAP (set beats clear), then reset mid-gap.
        request(1, 0, 0, 1, 1);
        for (int c = 0; c < 3; c++) begin
            step(); in_token = 0; halt = 0; tx_data_ready = 0; #1;
        end
        step(); in_token = 1; clear_status = 1; #1;
        step(); in_token = 0; clear_status = 0; #1;
        chk("gap_set_beats_clear", req_overrun, 1);
        chk("gap_packet_stall", tx_packet, 3);
        step(); rst = 1; #1;
        step(); rst = 0; #1;
        chk("grst_tx_start", tx_start, 0);
        chk("grst_tx_packet", tx_packet, 0);
        chk("grst_busy", sched_busy, 0);
        chk("grst_data_sent", data_sent, 0);
        chk("grst_sched_error", sched_error, 0);
        chk("grst_overrun", req_overrun, 0);
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            step(); #1;
            cnt += int'(tx_start);
        end
        chk("grst_no_start", cnt, 0);

        // Encoder stuck active.
        request(1, 0, 0, 0, 1);
        wait_start("wd", lat, ovr1, busy1, errs);
`ifdef USB_TX_SCHED_WATCHDOG_EN
        errc = -1; ds_cnt = 0;
        for (int c = 1; c <= 1300; c++) begin
            step(); tx_transfer_active = 1; #1;
            ds_cnt += int'(data_sent);
            if (sched_error) begin
                errc = c;
                break;
            end
        end
        chk("wd_error_cycle", errc, 1201);
        step(); #1;
        chk("wd_busy_after", sched_busy, 0);
        step(); tx_transfer_active = 0; #1;
        for (int c = 0; c < 5; c++) begin
            step(); #1;
            ds_cnt += int'(data_sent);
        end
        chk("wd_no_data_sent", ds_cnt, 0);
`else
        cnt = 0; errc = 0;
        for (int c = 1; c <= 5100; c++) begin
            step(); tx_transfer_active = 1; #1;
            cnt += int'(!sched_busy);
            errc += int'(sched_error);
        end
        chk("nowd_busy_held", cnt, 0);
        chk("nowd_no_error", errc, 0);
        run_tx(0, ds_cnt, err_cnt, st_cnt, ds_off, busy_end);
        chk("nowd_data_sent", ds_cnt, 1);
        chk("nowd_busy_end", busy_end, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/usb_tx_sched.md
Name: usb_tx_sched

Overview:
- Response scheduler sitting directly in front of the USB TX encoder.
- Takes token/data-phase events from the RX side plus endpoint status, picks the handshake or data packet to send (DATA0/ACK/NAK/STALL), enforces the inter-packet gap, pulses tx_start, and tracks the transfer to completion.
- Reports completion/error to the AHB-side buffer controller so DATA0 payloads are released only after a clean send.

Parameters:
- CLKS_PER_BIT, 8, system clocks per USB bit time; matches the TX divider rollover.
- IPG_BITS, 2, minimum bit times between request acceptance and tx_start; 0 means no gap.
- START_TIMEOUT, 16, clocks allowed from tx_start for tx_transfer_active to rise.
- MAX_TX_CYCLES, 1200, BUSY watchdog limit in clocks; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_token  in  1  pulse: IN token addressed to this endpoint received
- out_done  in  1  pulse: OUT data packet received with good CRC
- out_ok  in  1  qualifies out_done: 1 = data accepted, 0 = no room
- halt  in  1  endpoint halted
- tx_data_ready  in  1  software has committed an IN payload
- tx_transfer_active  in  1  from TX encoder
- tx_error  in  1  from TX encoder
- clear_status  in  1  pulse: clears sticky req_overrun
- tx_start  out  1  one-cycle start pulse to TX encoder
- tx_packet  out  2  0 = DATA0, 1 = ACK, 2 = NAK, 3 = STALL
- sched_busy  out  1  high in any state except IDLE
- data_sent  out  1  pulse: DATA0 completed without error
- sched_error  out  1  pulse: start timeout, tx_error or watchdog abort
- req_overrun  out  1  sticky: request dropped

Behaviour:
- Reset: rst high at a clk edge forces IDLE. Reset values: tx_start=0, tx_packet=2'd0, sched_busy=0, data_sent=0, sched_error=0, req_overrun=0, all counters 0. Reset mid-transfer aborts with no pulses.
- Packet decision, latched in IDLE on a request:
  - in_token: halt gives STALL; else tx_data_ready gives DATA0; else NAK.
  - out_done: halt gives STALL; else out_ok gives ACK; else NAK.
- Simultaneous in_token and out_done in IDLE: in_token wins and req_overrun is set.
- Any request outside IDLE is dropped and sets req_overrun. req_overrun holds until clear_status; a set event in the same cycle as clear_status wins.
- tx_packet is registered at acceptance and held unchanged until the return to IDLE.
- States:
  - IDLE: on a request, latch the packet and go to GAP, or to START if IPG_BITS=0.
  - GAP: count IPG_BITS*CLKS_PER_BIT cycles, then go to START.
  - START: tx_start=1 for exactly this cycle; go to WAIT_ACT.
  - WAIT_ACT: tx_transfer_active=1 goes to BUSY. After START_TIMEOUT cycles without it, pulse sched_error and go to IDLE.
  - BUSY: tx_error=1 pulses sched_error and goes to IDLE. Otherwise tx_transfer_active falling to 0 goes to DONE.
  - DONE: one cycle. data_sent=1 if the latched packet is DATA0; then go to IDLE.
- Latency: request sampled at edge k, tx_start high in cycle k+1+IPG_BITS*CLKS_PER_BIT. Default: 17 cycles after the request cycle.
- Counters are sized by $clog2 of the largest terminal value and reset on every state entry.
- tx_error is ignored outside BUSY.
- data_sent and sched_error are mutually exclusive within one transfer.

Optional Feature:
- USB_TX_SCHED_WATCHDOG_EN
- Defined: BUSY counts clocks. Reaching MAX_TX_CYCLES without tx_transfer_active falling pulses sched_error and returns to IDLE; data_sent is not asserted.
- Undefined: BUSY waits indefinitely; the counter logic is absent.

Test Plan:
- in_token with tx_data_ready=1, halt=0 -> tx_packet=0, tx_start pulse exactly 17 cycles later. TX model goes active for 300 cycles -> DONE, then data_sent=1 for one cycle.
- out_done with out_ok=0 -> tx_packet=2 (NAK), one tx_start pulse, no data_sent. Repeat with halt=1 -> tx_packet=3 (STALL).
- in_token and out_done in the same cycle -> ACK never sent, tx_packet=0 or 2 per the in_token rule, req_overrun=1. clear_status -> req_overrun=0.
- tx_transfer_active held low after tx_start -> sched_error pulse 16 cycles after START, return to IDLE, sched_busy=0.
- tx_error asserted mid-BUSY of a DATA0 send -> sched_error=1, data_sent stays 0. rst asserted during GAP -> all outputs 0 the next cycle and no tx_start.
- With USB_TX_SCHED_WATCHDOG_EN: tx_transfer_active stuck high -> sched_error after 1200 BUSY cycles. Without the macro: stays BUSY for 5000 or more cycles.
